vx_warp_sched: RTL and testbench
================================

// Module: vx_warp_sched
// PURPOSE
//  Warp scheduler that sequences the fetch stage. It holds per-warp PC, thread mask and
//  active/stalled state, and picks one eligible warp per cycle, round-robin. It drives the
//  schedule request (wid, PC, tmask, uuid) into fetch. One fetch is in flight per warp.
//  Decode/branch logic unstalls a warp and spawn logic activates warps.
// PARAMETERS
//  NUM_WARPS    4             warp count, power of 2, >=2; WIDW = log2(NUM_WARPS)
//  NUM_THREADS  4             threads per warp (tmask width)
//  PC_WIDTH     31            PC width; one instruction = PC increment of 2
//  UUID_WIDTH   44            instruction uuid width
//  STARTUP_PC   31'h40000000  PC of warp 0 out of reset
// PORTS
//  clk             in   1            clock, all state on rising edge
//  reset_n         in   1            asynchronous active-low reset
//  spawn_valid     in   1            one-cycle pulse: activate warps in spawn_wmask
//  spawn_wmask     in   NUM_WARPS    warps to activate
//  spawn_pc        in   PC_WIDTH     start PC for spawned warps
//  unstall_valid   in   1            one-cycle pulse: in-flight instr of unstall_wid resolved
//  unstall_wid     in   WIDW         warp being released
//  unstall_br      in   1            1: load unstall_pc, else keep sequential PC
//  unstall_pc      in   PC_WIDTH     branch target
//  unstall_tmask   in   NUM_THREADS  new thread mask; all-zero retires the warp
//  sched_valid     out  1            schedule request valid
//  sched_ready     in   1            fetch accepts request
//  sched_wid       out  WIDW         warp id
//  sched_pc        out  PC_WIDTH     fetch PC
//  sched_tmask     out  NUM_THREADS  thread mask
//  sched_uuid      out  UUID_WIDTH   instruction uuid
//  busy            out  1            any warp active or request pending
// BEHAVIOUR
//  - Reset (async, reset_n=0). Warp 0 is active, unstalled, PC=STARTUP_PC, tmask=1.
//    Other warps are inactive. sched_valid=0. sched_wid/pc/tmask/uuid=0. busy=1.
//    RR pointer=NUM_WARPS-1. uuid counter=0.
//  - Eligible[w] = active[w] & ~stalled[w].
//  - Pick: first eligible warp after the RR pointer, searching upward with modulo wrap.
//  - Output register loads when (!sched_valid | fire), where fire = sched_valid & sched_ready.
//    It loads the picked warp if one exists, else sched_valid=0. Request appears 1 cycle after
//    a warp becomes eligible. Fire-to-next-request takes 0 bubbles.
//  - Outputs hold stable while sched_valid & !sched_ready. A valid request is never withdrawn.
//  - On load: picked warp stalled=1, its PC += 2 (wraps mod 2^PC_WIDTH), RR pointer = picked wid.
//  - uuid counter increments on fire and wraps to 0 after all-ones.
//  - Unstall: stalled[wid]=0. If unstall_br, PC[wid]=unstall_pc. tmask[wid]=unstall_tmask.
//    If unstall_tmask==0, then active[wid]=0.
//    Takes effect for the pick in the next cycle; a warp is never reissued in its unstall cycle.
//  - Unstall of a warp that is not stalled: ignored (no state change).
//  - Spawn: each inactive warp in spawn_wmask gets active=1, stalled=0, PC=spawn_pc,
//    tmask=all ones. Masked warps that are already active are unchanged.
//  - Spawn and unstall in the same cycle on the same warp: unstall wins (the warp was active).
//  - No eligible warp: sched_valid drops after the pending fire. busy stays 1 while any warp is
//    active, including stalled warps.
//  - All warps retired and no pending request: busy=0.
//  - Reset asserted mid-request: sched_valid clears immediately (async). No handshake completes.
// CONFIGURATION
//  SCHED_UUID_EN defined:  uuid counter present. sched_uuid = counter value at load
//    (registered with the other outputs).
//  SCHED_UUID_EN undefined: no counter. sched_uuid is constant 0.
// TESTING
//  1 Reset release, sched_ready=1: cycle 1 sched_valid=1, wid=0, pc=0x40000000, tmask=1, uuid=0.
//    No further request until unstall.
//  2 Unstall wid0, br=0, tmask=1 -> next request wid0, pc=0x40000002, uuid=1.
//    Unstall wid0, br=1, pc=0x40001000 -> next request pc=0x40001000.
//  3 Spawn wmask=4'b1110 at pc=0x100, all warps unstalled after each issue, sched_ready=1:
//    wid order 0,1,2,3,0,... Spawned warps use tmask=4'hF.
//  4 sched_ready=0 for 5 cycles while valid: wid/pc/tmask/uuid held constant. Drop on ready.
//    Then next request follows in the next cycle, with no bubble.
//  5 Unstall wid0 with tmask=0 (only warp active) -> sched_valid stays 0.
//    busy falls to 0 one cycle after the unstall.
//  6 Assert reset_n=0 mid-stream with a request pending -> sched_valid=0 asynchronously.
//    After release, scenario 1 repeats and the uuid restarts at 0.

Source files
------------

// File: rtl/vx_warp_sched.sv
// Round-robin warp scheduler feeding fetch: per-warp PC/tmask/active/stalled state and one registered request.
// Optional feature: define SCHED_UUID_EN to add the instruction uuid counter (otherwise sched_uuid is constant 0).
module vx_warp_sched #(
    parameter int                   NUM_WARPS   = 4,
    parameter int                   NUM_THREADS = 4,
    parameter int                   PC_WIDTH    = 31,
    parameter int                   UUID_WIDTH  = 44,
    parameter logic [PC_WIDTH-1:0]  STARTUP_PC  = 31'h40000000,
    localparam int                  WIDW        = $clog2(NUM_WARPS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    spawn_valid,
    input  logic [NUM_WARPS-1:0]    spawn_wmask,
    input  logic [PC_WIDTH-1:0]     spawn_pc,
    input  logic                    unstall_valid,
    input  logic [WIDW-1:0]         unstall_wid,
    input  logic                    unstall_br,
    input  logic [PC_WIDTH-1:0]     unstall_pc,
    input  logic [NUM_THREADS-1:0]  unstall_tmask,
    output logic                    sched_valid,
    input  logic                    sched_ready,
    output logic [WIDW-1:0]         sched_wid,
    output logic [PC_WIDTH-1:0]     sched_pc,
    output logic [NUM_THREADS-1:0]  sched_tmask,
    output logic [UUID_WIDTH-1:0]   sched_uuid,
    output logic                    busy
);

    logic [NUM_WARPS-1:0]   active_q;
    logic [NUM_WARPS-1:0]   stalled_q;
    logic [NUM_WARPS-1:0]   eligible;
    logic [PC_WIDTH-1:0]    pc_q    [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];

    logic [WIDW-1:0]        rr_q, rr_d;
    logic                   valid_q, valid_d;
    logic [WIDW-1:0]        wid_q, wid_d;
    logic [PC_WIDTH-1:0]    spc_q, spc_d;
    logic [NUM_THREADS-1:0] stmask_q, stmask_d;

    logic                   fire;
    logic                   load_en;
    logic                   pick_found;
    logic [WIDW-1:0]        pick_wid;
    logic [WIDW-1:0]        cand;

    assign eligible = active_q & ~stalled_q;
    assign fire     = valid_q & sched_ready;
    assign load_en  = ~valid_q | fire;

    // Walk downward so the nearest eligible warp after the RR pointer is the last (winning) hit.
    always_comb begin
        pick_found = 1'b0;
        pick_wid   = '0;
        cand       = '0;
        for (int i = NUM_WARPS; i >= 1; i--) begin
            cand = rr_q + WIDW'(i);
            if (eligible[cand]) begin
                pick_found = 1'b1;
                pick_wid   = cand;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
        logic                   active_d;
        logic                   stalled_d;
        logic [PC_WIDTH-1:0]    pc_d;
        logic [NUM_THREADS-1:0] tmask_d;

        // A picked warp is eligible, hence never stalled or inactive, so the three updates are disjoint.
        always_comb begin
            active_d  = active_q[gi];
            stalled_d = stalled_q[gi];
            pc_d      = pc_q[gi];
            tmask_d   = tmask_q[gi];
            if (unstall_valid && (unstall_wid == WIDW'(gi)) && stalled_q[gi]) begin
                stalled_d = 1'b0;
                tmask_d   = unstall_tmask;
                if (unstall_br) begin
                    pc_d = unstall_pc;
                end
                if (unstall_tmask == '0) begin
                    active_d = 1'b0;
                end
            end
            if (spawn_valid && spawn_wmask[gi] && !active_q[gi]) begin
                active_d  = 1'b1;
                stalled_d = 1'b0;
                pc_d      = spawn_pc;
                tmask_d   = '1;
            end
            if (load_en && pick_found && (pick_wid == WIDW'(gi))) begin
                stalled_d = 1'b1;
                pc_d      = pc_q[gi] + PC_WIDTH'(2);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                active_q[gi]  <= (gi == 0);
                stalled_q[gi] <= 1'b0;
                pc_q[gi]      <= (gi == 0) ? STARTUP_PC : '0;
                tmask_q[gi]   <= (gi == 0) ? NUM_THREADS'(1) : '0;
            end else begin
                active_q[gi]  <= active_d;
                stalled_q[gi] <= stalled_d;
                pc_q[gi]      <= pc_d;
                tmask_q[gi]   <= tmask_d;
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        wid_d    = wid_q;
        spc_d    = spc_q;
        stmask_d = stmask_q;
        rr_d     = rr_q;
        if (load_en) begin
            valid_d = pick_found;
            if (pick_found) begin
                wid_d    = pick_wid;
                spc_d    = pc_q[pick_wid];
                stmask_d = tmask_q[pick_wid];
                rr_d     = pick_wid;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            wid_q    <= '0;
            spc_q    <= '0;
            stmask_q <= '0;
            rr_q     <= WIDW'(NUM_WARPS - 1);
        end else begin
            valid_q  <= valid_d;
            wid_q    <= wid_d;
            spc_q    <= spc_d;
            stmask_q <= stmask_d;
            rr_q     <= rr_d;
        end
    end

`ifdef SCHED_UUID_EN
    logic [UUID_WIDTH-1:0] uuid_cnt_q, uuid_cnt_d;
    logic [UUID_WIDTH-1:0] uuid_q, uuid_d;

    // A request loaded on the fire edge takes the post-increment value so uuids stay unique.
    always_comb begin
        uuid_cnt_d = uuid_cnt_q + UUID_WIDTH'(fire);
        uuid_d     = uuid_q;
        if (load_en && pick_found) begin
            uuid_d = uuid_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uuid_cnt_q <= '0;
            uuid_q     <= '0;
        end else begin
            uuid_cnt_q <= uuid_cnt_d;
            uuid_q     <= uuid_d;
        end
    end

    assign sched_uuid = uuid_q;
`else
    assign sched_uuid = '0;
`endif

    assign sched_valid = valid_q;
    assign sched_wid   = wid_q;
    assign sched_pc    = spc_q;
    assign sched_tmask = stmask_q;
    assign busy        = (|active_q) | valid_q;

endmodule

// File: tb/tb_vx_warp_sched.sv
// Scoreboard bench for vx_warp_sched: directed stimulus pushes expected requests, a monitor pops on each fire.
module tb_vx_warp_sched;
    localparam int NW   = 4;
    localparam int NT   = 4;
    localparam int PCW  = 31;
    localparam int UW   = 44;
    localparam int WIDW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            spawn_valid;
    logic [NW-1:0]   spawn_wmask;
    logic [PCW-1:0]  spawn_pc;
    logic            unstall_valid;
    logic [WIDW-1:0] unstall_wid;
    logic            unstall_br;
    logic [PCW-1:0]  unstall_pc;
    logic [NT-1:0]   unstall_tmask;
    logic            sched_valid;
    logic            sched_ready;
    logic [WIDW-1:0] sched_wid;
    logic [PCW-1:0]  sched_pc;
    logic [NT-1:0]   sched_tmask;
    logic [UW-1:0]   sched_uuid;
    logic            busy;

    always #5 clk = ~clk;

    vx_warp_sched dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .spawn_valid   (spawn_valid),
        .spawn_wmask   (spawn_wmask),
        .spawn_pc      (spawn_pc),
        .unstall_valid (unstall_valid),
        .unstall_wid   (unstall_wid),
        .unstall_br    (unstall_br),
        .unstall_pc    (unstall_pc),
        .unstall_tmask (unstall_tmask),
        .sched_valid   (sched_valid),
        .sched_ready   (sched_ready),
        .sched_wid     (sched_wid),
        .sched_pc      (sched_pc),
        .sched_tmask   (sched_tmask),
        .sched_uuid    (sched_uuid),
        .busy          (busy)
    );

    typedef struct packed {
        logic [WIDW-1:0] wid;
        logic [PCW-1:0]  pc;
        logic [NT-1:0]   tmask;
        logic [UW-1:0]   uuid;
    } req_t;

    req_t          sb_q[$];
    int            checks;
    int            failures;
    logic [UW-1:0] uuid_model;
    int            auto_budget;
    logic          hold_v;
    req_t          hold_r;
    req_t          mon_cur;
    req_t          mon_exp;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_req(input string nm, input req_t act, input req_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual wid=%0d pc=%h tmask=%h uuid=%0d required wid=%0d pc=%h tmask=%h uuid=%0d",
                     nm, act.wid, act.pc, act.tmask, act.uuid, exp.wid, exp.pc, exp.tmask, exp.uuid);
        end
    endtask

    task automatic push(input logic [WIDW-1:0] w, input logic [PCW-1:0] pc, input logic [NT-1:0] tm);
        req_t r;
        r.wid   = w;
        r.pc    = pc;
        r.tmask = tm;
`ifdef SCHED_UUID_EN
        r.uuid  = uuid_model;
`else
        r.uuid  = '0;
`endif
        uuid_model = uuid_model + 1'b1;
        sb_q.push_back(r);
    endtask

    // One clock: sample at negedge, drive 1 time unit after the rising edge; optionally echo an unstall.
    task automatic step();
        logic            fs;
        logic [WIDW-1:0] fw;
        logic [NT-1:0]   ft;
        @(negedge clk);
        fs = sched_valid && sched_ready && reset_n;
        fw = sched_wid;
        ft = sched_tmask;
        @(posedge clk);
        #1;
        spawn_valid   = 1'b0;
        unstall_valid = 1'b0;
        unstall_br    = 1'b0;
        if (fs && auto_budget > 0) begin
            auto_budget   = auto_budget - 1;
            unstall_valid = 1'b1;
            unstall_wid   = fw;
            unstall_tmask = ft;
        end
    endtask

    task automatic unstall(input logic [WIDW-1:0] w, input logic br, input logic [PCW-1:0] pc,
                           input logic [NT-1:0] tm);
        unstall_valid = 1'b1;
        unstall_wid   = w;
        unstall_br    = br;
        unstall_pc    = pc;
        unstall_tmask = tm;
    endtask

    task automatic spawn(input logic [NW-1:0] m, input logic [PCW-1:0] pc);
        spawn_valid = 1'b1;
        spawn_wmask = m;
        spawn_pc    = pc;
    endtask

    task automatic drain(input int max_cyc, input string nm);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s timeout pending=%0d required=0", nm, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        reset_n       = 1'b1;
        spawn_valid   = 1'b0;
        spawn_wmask   = '0;
        spawn_pc      = '0;
        unstall_valid = 1'b0;
        unstall_wid   = '0;
        unstall_br    = 1'b0;
        unstall_pc    = '0;
        unstall_tmask = '0;
        sched_ready   = 1'b1;
        checks        = 0;
        failures      = 0;
        uuid_model    = '0;
        auto_budget   = 0;
        hold_v        = 1'b0;
        hold_r        = '0;

        fork
            forever begin
                @(negedge clk);
                mon_cur = '{wid: sched_wid, pc: sched_pc, tmask: sched_tmask, uuid: sched_uuid};
                if (!reset_n) begin
                    hold_v = 1'b0;
                end else begin
                    if (hold_v) begin
                        check("hold_valid", 64'(sched_valid), 64'd1);
                        cmp_req("hold_fields", mon_cur, hold_r);
                    end
                    hold_v = sched_valid && !sched_ready;
                    hold_r = mon_cur;
                    if (sched_valid && sched_ready) begin
                        if (sb_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_request actual wid=%0d pc=%h required none",
                                     sched_wid, sched_pc);
                        end else begin
                            mon_exp = sb_q.pop_front();
                            cmp_req("request", mon_cur, mon_exp);
                            $display("txn wid=%0d pc=%h tmask=%h uuid=%0d",
                                     mon_cur.wid, mon_cur.pc, mon_cur.tmask, mon_cur.uuid);
                        end
                    end
                end
            end
        join_none

        // Reset state and first request
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(sched_valid), 64'd0);
        check("rst_wid",   64'(sched_wid),   64'd0);
        check("rst_pc",    64'(sched_pc),    64'd0);
        check("rst_tmask", 64'(sched_tmask), 64'd0);
        check("rst_uuid",  64'(sched_uuid),  64'd0);
        check("rst_busy",  64'(busy),        64'd1);
        reset_n = 1'b1;
        push(2'd0, 31'h40000000, 4'h1);
        step();
        check("s1_valid_cycle1", 64'(sched_valid), 64'd1);
        repeat (3) begin
            step();
            check("s1_no_reissue", 64'(sched_valid), 64'd0);
        end
        check("s1_busy_stalled", 64'(busy), 64'd1);

        // Sequential and branch unstall
        unstall(2'd0, 1'b0, 31'h0, 4'h1);
        push(2'd0, 31'h40000002, 4'h1);
        drain(20, "s2_seq");
        unstall(2'd0, 1'b1, 31'h40001000, 4'h1);
        push(2'd0, 31'h40001000, 4'h1);
        drain(20, "s2_br");

        // Spawn three warps; each issue is echoed back as an unstall for the first round
        spawn(4'b1110, 31'h100);
        unstall(2'd0, 1'b0, 31'h0, 4'h1);
        auto_budget = 4;
        push(2'd1, 31'h100, 4'hF);
        push(2'd2, 31'h100, 4'hF);
        push(2'd3, 31'h100, 4'hF);
        push(2'd0, 31'h40001002, 4'h1);
        push(2'd1, 31'h102, 4'hF);
        push(2'd2, 31'h102, 4'hF);
        push(2'd3, 31'h102, 4'hF);
        push(2'd0, 31'h40001004, 4'h1);
        drain(40, "s3_rr");
        step();
        check("s3_all_stalled", 64'(sched_valid), 64'd0);

        // Backpressure: request held, then zero-bubble follow-up
        sched_ready = 1'b0;
        unstall(2'd0, 1'b0, 31'h0, 4'h1);
        step();
        unstall(2'd1, 1'b0, 31'h0, 4'hF);
        push(2'd0, 31'h40001006, 4'h1);
        push(2'd1, 31'h104, 4'hF);
        repeat (6) step();
        check("s4_valid_held", 64'(sched_valid), 64'd1);
        check("s4_wid_held",   64'(sched_wid),   64'd0);
        sched_ready = 1'b1;
        step();
        check("s4_no_bubble_valid", 64'(sched_valid), 64'd1);
        check("s4_no_bubble_wid",   64'(sched_wid),   64'd1);
        drain(10, "s4_drain");

        // Retire all warps
        step();
        unstall(2'd3, 1'b0, 31'h0, 4'h0);
        step();
        unstall(2'd2, 1'b0, 31'h0, 4'h0);
        step();
        unstall(2'd1, 1'b0, 31'h0, 4'h0);
        step();
        check("s5_busy_w0_left", 64'(busy), 64'd1);
        check("s5_valid_w0_left", 64'(sched_valid), 64'd0);
        unstall(2'd0, 1'b0, 31'h0, 4'h0);
        check("s5_busy_before", 64'(busy), 64'd1);
        step();
        check("s5_busy_after", 64'(busy), 64'd0);
        repeat (2) begin
            step();
            check("s5_valid_idle", 64'(sched_valid), 64'd0);
        end

        // Asynchronous reset with a request pending
        sched_ready = 1'b0;
        spawn(4'b0001, 31'h200);
        step();
        step();
        check("s6_pending_valid", 64'(sched_valid), 64'd1);
        check("s6_pending_pc",    64'(sched_pc),    64'h200);
        check("s6_pending_tmask", 64'(sched_tmask), 64'hF);
        #3 reset_n = 1'b0;
        #1;
        check("s6_async_valid", 64'(sched_valid), 64'd0);
        check("s6_async_pc",    64'(sched_pc),    64'd0);
        check("s6_async_busy",  64'(busy),        64'd1);
        step();
        step();
        reset_n     = 1'b1;
        sched_ready = 1'b1;
        uuid_model  = '0;
        push(2'd0, 31'h40000000, 4'h1);
        step();
        check("s6_restart_valid", 64'(sched_valid), 64'd1);
        drain(10, "s6_restart");
        unstall(2'd0, 1'b0, 31'h0, 4'h1);
        push(2'd0, 31'h40000002, 4'h1);
        drain(20, "s6_seq");
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
